axi_wr_slv_mem: RTL and testbench

- AXI4 write-path responder that consumes the AW/W traffic the master drives and stores it in an internal byte-strobed memory.
- Returns one B response per burst.
- Sits directly downstream of the master-side AXI interface and acts as the RTL slave endpoint for write-path checks.
- A registered backdoor read port exposes memory contents to the scoreboard.

---
 rtl/axi_wr_slv_mem_pkg.sv | 25 ++
 rtl/axi_wr_slv_mem_if.sv | 41 ++++
 rtl/axi_wr_slv_mem_addr_gen.sv | 35 +++
 rtl/axi_wr_slv_mem.sv | 138 +++++++++++++
 tb/tb_axi_wr_slv_mem.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_wr_slv_mem_pkg.sv
// axi_slv_pkg: burst/response encodings, FSM states and sizing helpers shared
// by the AXI write-path responder and its address generator.
package axi_slv_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      RESP = 2'b10
   } wr_state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   function automatic logic [7:0] bytes_per_beat(input logic [2:0] size);
      return 8'd1 << size;
   endfunction

endpackage

// File: rtl/axi_wr_slv_mem_if.sv
// axi_wr_slv_mem_if: AXI4 write-path channels (AW, W, B) with master and
// slave views.
interface axi_wr_slv_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);

   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [ID_WIDTH-1:0]     wid;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wid, wdata, wstrb, wlast, wvalid,
      output bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid,
      input  bready,
      output awready, wready, bid, bresp, bvalid
   );

endinterface

// File: rtl/axi_wr_slv_mem_addr_gen.sv
// axi_burst_addr_gen: combinational AXI next-beat address and illegal-burst
// detection, shared between write and read paths.
module axi_burst_addr_gen
   import axi_slv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [7:0]            len_i,
   input  burst_t                burst_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o,
   output logic                  illegal_o
);

   localparam int MAX_SIZE = $clog2(DATA_WIDTH/8);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] bnd_mask;
   logic [ADDR_WIDTH-1:0] wrap_addr;

   assign step      = ADDR_WIDTH'(bytes_per_beat(size_i));
   assign bnd_mask  = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
   assign wrap_addr = (addr_i & ~bnd_mask) | ((addr_i + step) & bnd_mask);

   assign next_addr_o = burst_i == INCR ? addr_i + step :
                        burst_i == WRAP ? wrap_addr : addr_i;

   // WRAP boundaries must be power-of-two beat counts of 2..16
   assign illegal_o = burst_i == RSVD ||
                      size_i > 3'(MAX_SIZE) ||
                      (burst_i == WRAP && !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));

endmodule

// File: rtl/axi_wr_slv_mem.sv
// axi_wr_slv_mem: AXI4 write responder storing strobed beats in local memory,
// one burst outstanding, with a registered backdoor read port.
module axi_wr_slv_mem
   import axi_slv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  aclk,
   input  logic                  areset,
   axi_wr_slv_mem_if.slave       bus,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_rdata
);

   localparam int NB   = DATA_WIDTH/8;
   localparam int OFFS = $clog2(NB);
   localparam int IW   = $clog2(MEM_DEPTH);

   wr_state_t             state_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ID_WIDTH-1:0]   bid_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic [2:0]            size_q;
   burst_t                burst_q;
   logic                  err_q;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [DATA_WIDTH-1:0] dbg_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] widx;
   logic [ADDR_WIDTH-1:0] didx;
   logic                  illegal;
   logic                  beat;
   logic                  last;
   logic                  wr_en;
   logic                  beat_err;

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_addr_gen (
      .addr_i      (addr_q),
      .size_i      (size_q),
      .len_i       (len_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr),
      .illegal_o   (illegal)
   );

   assign widx     = addr_q >> OFFS;
   assign didx     = dbg_addr >> OFFS;
   assign beat     = bus.wvalid && wready_q;
   assign last     = bus.wlast || cnt_q == len_q;
   assign wr_en    = beat && !areset && !illegal && widx < ADDR_WIDTH'(MEM_DEPTH) && bus.wid == id_q;
   // wlast must coincide exactly with the final counted beat
   assign beat_err = !wr_en || (bus.wlast != (cnt_q == len_q));

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         bid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (awready_q && bus.awvalid) begin
                  id_q      <= bus.awid;
                  addr_q    <= bus.awaddr;
                  len_q     <= bus.awlen;
                  size_q    <= bus.awsize;
                  burst_q   <= burst_t'(bus.awburst);
                  cnt_q     <= 8'd0;
                  err_q     <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  state_q   <= DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            DATA: begin
               if (beat) begin
                  addr_q <= next_addr;
                  cnt_q  <= cnt_q + 8'd1;
                  err_q  <= err_q || beat_err;
                  if (last) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= (err_q || beat_err) ? SLVERR : OKAY;
                     state_q  <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en)
         for (int b = 0; b < NB; b++)
            if (bus.wstrb[b]) mem[widx[IW-1:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
   end

   always_ff @(posedge aclk) begin
      if (areset) dbg_q <= '0;
      else dbg_q <= didx < ADDR_WIDTH'(MEM_DEPTH) ? mem[didx[IW-1:0]] : '0;
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.bid     = bid_q;
   assign dbg_rdata   = dbg_q;

endmodule

// File: tb/tb_axi_wr_slv_mem.sv
// tb_axi_wr_slv_mem: directed and random AXI write bursts checked against a
// byte-level memory model driven by the burst address rules.
module tb_axi_wr_slv_mem;
   import axi_slv_pkg::*;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] dbg_addr = '0;
   logic [31:0] dbg_rdata;

   always #5 aclk = ~aclk;

   axi_wr_slv_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi_wr_slv_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ID_WIDTH   (4),
      .MEM_DEPTH  (1024)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .bus       (bus.slave),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   int total = 0;
   int bad = 0;

   logic [31:0] mm [1024];
   logic [3:0]  kn [1024];
   logic [31:0] dq [$];
   logic [3:0]  sq [$];

   logic [3:0]  c_id;
   logic [31:0] c_a;
   logic [7:0]  c_len;
   logic [2:0]  c_sz;
   logic [1:0]  c_bt;
   logic        c_legal;
   logic        c_err;
   int          c_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m32(input logic [3:0] k);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
      return m;
   endfunction

   function automatic logic legal(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
      return bt != 2'b11 && sz <= 3'd2 && (bt != 2'b10 || len inside {8'd1, 8'd3, 8'd7, 8'd15});
   endfunction

   // address of beat i: FIXED repeats, INCR strides, WRAP cycles inside its aligned window
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] sz, input logic [1:0] bt, input int i);
      logic [31:0] nb, win, lo;
      nb  = 32'd1 << sz;
      win = (32'(len) + 32'd1) * nb;
      lo  = a - (a % win);
      if (bt == 2'b01) return a + 32'(i) * nb;
      if (bt == 2'b10) return lo + ((a - lo) + 32'(i) * nb) % win;
      return a;
   endfunction

   task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt);
      int k = 0;
      c_id = id; c_a = a; c_len = len; c_sz = sz; c_bt = bt;
      c_legal = legal(len, sz, bt);
      c_err = !c_legal;
      c_i = 0;
      @(negedge aclk);
      bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bt;
      bus.awvalid = 1'b1;
      while (!bus.awready && k < 20) begin @(negedge aclk); k++; end
      chk("aw_ready", 32'(bus.awready), 32'd1);
      @(posedge aclk);
      @(negedge aclk);
      bus.awvalid = 1'b0;
      chk("aw_to_wready", 32'(bus.wready), 32'd1);
   endtask

   task automatic w_beat(input logic [3:0] wid, input logic wl);
      logic [31:0] wa, w, d;
      logic [3:0]  s;
      logic        ok;
      int          k = 0;
      wa = beat_addr(c_a, c_len, c_sz, c_bt, c_i);
      w  = wa >> 2;
      d  = dq.size() > 0 ? dq.pop_front() : $urandom;
      s  = sq.size() > 0 ? sq.pop_front() : 4'($urandom);
      bus.wid = wid; bus.wdata = d; bus.wstrb = s; bus.wlast = wl; bus.wvalid = 1'b1;
      dbg_addr = wa;
      while (!bus.wready && k < 20) begin @(negedge aclk); k++; end
      chk("w_ready", 32'(bus.wready), 32'd1);
      @(posedge aclk);
      @(negedge aclk);
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
      if (w >= 32'd1024) chk("rbw_oor", dbg_rdata, 32'd0);
      else if (kn[w] != 4'd0) chk("rbw_old", dbg_rdata & m32(kn[w]), mm[w] & m32(kn[w]));
      ok = c_legal && w < 32'd1024 && wid == c_id;
      if (ok)
         for (int b = 0; b < 4; b++)
            if (s[b]) begin mm[w][b*8 +: 8] = d[b*8 +: 8]; kn[w][b] = 1'b1; end
      c_err = c_err || !ok || (wl != (c_i == int'(c_len)));
      c_i++;
   endtask

   task automatic burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bt, input int last_at, input int bad_at);
      int i = 0;
      aw_send(id, a, len, sz, bt);
      while (1) begin
         w_beat(i == bad_at ? id ^ 4'h1 : id, i == last_at);
         if (i == last_at || i == int'(len)) break;
         i++;
      end
      chk("b_latency", 32'(bus.bvalid), 32'd1);
      chk("w_closed", 32'(bus.wready), 32'd0);
      if (last_at > int'(len)) begin
         bus.wvalid = 1'b1;
         repeat (2) begin @(negedge aclk); chk("extra_w_blocked", 32'(bus.wready), 32'd0); end
         bus.wvalid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
         @(negedge aclk);
         chk("b_hold", 32'(bus.bvalid), 32'd1);
      end
      chk("bid", 32'(bus.bid), 32'(c_id));
      chk("bresp", 32'(bus.bresp), c_err ? 32'd2 : 32'd0);
      bus.bready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      bus.bready = 1'b0;
      chk("b_done", 32'(bus.bvalid), 32'd0);
      chk("aw_reopen", 32'(bus.awready), 32'd1);
   endtask

   task automatic rd_chk(input logic [31:0] a);
      logic [31:0] w;
      w = a >> 2;
      @(negedge aclk);
      dbg_addr = a;
      @(negedge aclk);
      if (w >= 32'd1024) chk("dbg_oor", dbg_rdata, 32'd0);
      else chk("dbg_mem", dbg_rdata & m32(kn[w]), mm[w] & m32(kn[w]));
   endtask

   initial begin
      logic [7:0]  wlens [4] = '{8'd1, 8'd3, 8'd7, 8'd15};
      logic [1:0]  bt;
      logic [2:0]  sz;
      logic [7:0]  len;
      logic [31:0] a;
      for (int w = 0; w < 1024; w++) begin mm[w] = '0; kn[w] = '0; end
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
      bus.wvalid = 1'b0; bus.bready = 1'b0;

      repeat (3) @(negedge aclk);
      chk("rst_awready", 32'(bus.awready), 32'd0);
      chk("rst_wready", 32'(bus.wready), 32'd0);
      chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("rst_bresp", 32'(bus.bresp), 32'd0);
      chk("rst_bid", 32'(bus.bid), 32'd0);
      chk("rst_dbg", dbg_rdata, 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("post_rst_awready", 32'(bus.awready), 32'd1);

      for (int i = 0; i < 4; i++) begin dq.push_back(32'hA0 + 32'(i)); sq.push_back(4'hF); end
      burst(4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 3, -1);
      for (int i = 0; i < 4; i++) rd_chk(32'h100 + 32'(i) * 4);
      chk("t1_last_word", dbg_rdata, 32'hA3);

      for (int i = 0; i < 4; i++) begin dq.push_back(32'hD0 + 32'(i)); sq.push_back(4'hF); end
      burst(4'h2, 32'h08, 8'd3, 3'd2, 2'b10, 3, -1);
      rd_chk(32'h00);
      chk("t2_wrap_word0", dbg_rdata, 32'hD2);
      rd_chk(32'h0C);

      dq.push_back(32'h12345678); sq.push_back(4'hF);
      burst(4'h3, 32'h20, 8'd0, 3'd2, 2'b01, 0, -1);
      dq.push_back(32'hFFFFFFFF); sq.push_back(4'b0101);
      burst(4'h3, 32'h20, 8'd0, 3'd2, 2'b01, 0, -1);
      rd_chk(32'h20);
      chk("t3_strobe_merge", dbg_rdata, 32'h12FF56FF);

      burst(4'h1, 32'h100, 8'd1, 3'd2, 2'b11, 1, -1);
      rd_chk(32'h100);
      rd_chk(32'h104);
      burst(4'hE, 32'd4096, 8'd1, 3'd2, 2'b01, 1, -1);
      rd_chk(32'd4096);
      burst(4'h4, 32'h200, 8'd3, 3'd2, 2'b01, 1, -1);
      burst(4'h5, 32'h240, 8'd3, 3'd2, 2'b01, 3, 2);
      burst(4'h6, 32'h280, 8'd1, 3'd2, 2'b01, 99, -1);
      burst(4'h7, 32'h2C0, 8'd2, 3'd2, 2'b10, 2, -1);
      burst(4'h8, 32'h2E0, 8'd0, 3'd3, 2'b01, 0, -1);
      burst(4'hA, 32'h3FC, 8'd1, 3'd1, 2'b00, 1, -1);

      aw_send(4'h9, 32'h300, 8'd3, 3'd2, 2'b01);
      w_beat(4'h9, 1'b0);
      areset = 1'b1;
      @(negedge aclk);
      chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("mid_rst_wready", 32'(bus.wready), 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("mid_rst_awready", 32'(bus.awready), 32'd1);
      chk("mid_rst_no_b", 32'(bus.bvalid), 32'd0);
      rd_chk(32'h300);

      for (int n = 0; n < 30; n++) begin
         bt  = 2'($urandom_range(0, 2));
         sz  = 3'($urandom_range(0, 2));
         len = bt == 2'b10 ? wlens[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
         a   = (32'($urandom_range(0, 1023)) << 2) | ((32'($urandom_range(0, 3)) >> sz) << sz);
         burst(4'($urandom), a, len, sz, bt, int'(len), $urandom_range(0, 7) == 0 ? 0 : -1);
      end

      for (int w = 0; w < 1024; w++)
         if (kn[w] != 4'd0) rd_chk(32'(w) << 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
